// File: rtl/prio_queue.sv
// ---------------------------------------------------------------------------
// prio_queue
//
// Min-priority event queue for the PHOLD simulator core. Events are kept in a
// fully sorted register array: slot[0] always holds the smallest stored
// event. One insert and/or one remove can happen on each rising clock edge.
// All outputs come straight from registers, so no input reaches an output
// through combinational logic.
//
// Parameters
//   WIDTH  event word width; the whole word is the unsigned sort key
//   DEPTH  maximum number of stored events
//   CNT_W  width of count; must be able to hold 0..DEPTH
//
// Ports
//   CLK       in   1      clock, rising edge
//   rst_n     in   1      asynchronous active-low reset, clears all contents
//   enq       in   1      insert inp_data this cycle
//   deq       in   1      remove the current head this cycle
//   inp_data  in   WIDTH  event to insert
//   out_data  out  WIDTH  current minimum event (0 when empty)
//   count     out  CNT_W  number of stored events
// ---------------------------------------------------------------------------
module prio_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] inp_data,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] slot_reg  [DEPTH];
  logic [WIDTH-1:0] slot_next [DEPTH];

  // Contents after an optional removal, before the optional insertion.
  logic [WIDTH-1:0] base      [DEPTH];
  logic [CNT_W-1:0] base_cnt;

  // after_ins[i]: slot i of base lies at or after the insertion point, i.e.
  // it is empty or holds a word larger than inp_data. Because base is sorted
  // and empties sit at the tail, this vector is monotone (0...01...1).
  logic [DEPTH-1:0] after_ins;

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             deq_ok;
  logic             enq_ok;

  // A remove is only meaningful with something stored. An insert is dropped
  // when full, unless a remove in the same cycle frees a slot.
  assign deq_ok     = deq && (count_reg != '0);
  assign enq_ok     = enq && ((count_reg < CNT_W'(DEPTH)) || deq_ok);
  assign base_cnt   = deq_ok ? (count_reg - CNT_W'(1)) : count_reg;
  assign count_next = base_cnt + CNT_W'(enq_ok);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Removal shifts everything one place toward the head; the tail slot
      // is refilled with zero so vacated slots always read as 0.
      if (gi == DEPTH - 1) begin : g_tail
        assign base[gi] = deq_ok ? '0 : slot_reg[gi];
      end else begin : g_body
        assign base[gi] = deq_ok ? slot_reg[gi+1] : slot_reg[gi];
      end

      assign after_ins[gi] = (CNT_W'(gi) >= base_cnt) || (base[gi] > inp_data);

      // Slots before the insertion point keep their value, the first slot at
      // the insertion point takes inp_data, later slots take their
      // predecessor (shift one place toward the tail).
      if (gi == 0) begin : g_head
        assign slot_next[gi] = (enq_ok && after_ins[gi]) ? inp_data : base[gi];
      end else begin : g_rest
        always_comb begin
          slot_next[gi] = base[gi];
          if (enq_ok && after_ins[gi]) begin
            slot_next[gi] = after_ins[gi-1] ? base[gi-1] : inp_data;
          end
        end
      end

      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg[gi] <= '0;
        end else begin
          slot_reg[gi] <= slot_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign out_data = slot_reg[0];
  assign count    = count_reg;

endmodule

// File: tb/tb_prio_queue.sv
// ---------------------------------------------------------------------------
// tb_prio_queue
//
// Directed bench for prio_queue. A table of {enq, deq, data, expected head,
// expected count} records is applied one clock per record; asynchronous
// reset behaviour is exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_prio_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             CLK;
  logic             rst_n;
  logic             enq;
  logic             deq;
  logic [WIDTH-1:0] inp_data;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  int n_checks;
  int n_fail;

  typedef struct {
    logic             enq;
    logic             deq;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] exp_out;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  prio_queue #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .enq      (enq),
    .deq      (deq),
    .inp_data (inp_data),
    .out_data (out_data),
    .count    (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic e, input logic d, input logic [WIDTH-1:0] dat,
                              input logic [WIDTH-1:0] eo, input int ec);
    vec_t v;
    v.enq     = e;
    v.deq     = d;
    v.data    = dat;
    v.exp_out = eo;
    v.exp_cnt = CNT_W'(ec);
    return v;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] eo, input logic [CNT_W-1:0] ec);
    n_checks++;
    if (out_data !== eo) begin
      n_fail++;
      $display("FAIL %s out_data: got %h expected %h", name, out_data, eo);
    end
    n_checks++;
    if (count !== ec) begin
      n_fail++;
      $display("FAIL %s count: got %0d expected %0d", name, count, ec);
    end
  endtask

  // Drive inputs on the falling edge, let the rising edge act, sample 1 ns later.
  task automatic step(input logic e, input logic d, input logic [WIDTH-1:0] dat);
    @(negedge CLK);
    enq      = e;
    deq      = d;
    inp_data = dat;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    enq      = 1'b0;
    deq      = 1'b0;
    inp_data = '0;
    rst_n    = 1'b0;

    // ---------------- vector table ----------------
    vecs.push_back(mk(0, 1, 16'h0000, 16'h0000, 0));  // deq while empty
    vecs.push_back(mk(1, 0, 16'h0031, 16'h0031, 1));
    vecs.push_back(mk(1, 0, 16'h0012, 16'h0012, 2));
    vecs.push_back(mk(1, 0, 16'h0020, 16'h0012, 3));
    vecs.push_back(mk(0, 1, 16'h0000, 16'h0020, 2));
    vecs.push_back(mk(0, 1, 16'h0000, 16'h0031, 1));
    vecs.push_back(mk(0, 1, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 16'h0042, 16'h0042, 1));  // enq+deq while empty
    vecs.push_back(mk(0, 1, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 16'h0010, 16'h0010, 1));
    vecs.push_back(mk(1, 0, 16'h0030, 16'h0010, 2));
    vecs.push_back(mk(1, 1, 16'h0020, 16'h0020, 2));  // {0030}+0020
    vecs.push_back(mk(1, 1, 16'h0005, 16'h0005, 2));  // {0030}+0005
    vecs.push_back(mk(0, 1, 16'h0000, 16'h0030, 1));
    vecs.push_back(mk(0, 1, 16'h0000, 16'h0000, 0));
    for (int i = 0; i < DEPTH; i++) begin
      vecs.push_back(mk(1, 0, 16'h0100 + 16'(i), 16'h0100, i + 1));
    end
    vecs.push_back(mk(1, 0, 16'h0001, 16'h0100, 16));  // full: insert dropped
    vecs.push_back(mk(1, 1, 16'h0001, 16'h0001, 16));  // full: enq+deq swaps head
    vecs.push_back(mk(0, 1, 16'h0000, 16'h0101, 15));
    vecs.push_back(mk(1, 0, 16'h0200, 16'h0101, 16));  // lands at the tail
    vecs.push_back(mk(0, 1, 16'h0000, 16'h0102, 15));
    // Held deq drains {0102..010F, 0200}, one per edge, then stays empty.
    for (int k = 1; k <= 15; k++) begin
      logic [WIDTH-1:0] eo;
      if (k <= 13)      eo = 16'h0102 + 16'(k);
      else if (k == 14) eo = 16'h0200;
      else              eo = 16'h0000;
      vecs.push_back(mk(0, 1, 16'h0000, eo, 15 - k));
    end
    vecs.push_back(mk(0, 1, 16'h0000, 16'h0000, 0));

    // ---------------- reset ----------------
    #12;
    check("reset_hold", 16'h0000, 5'd0);
    @(posedge CLK);
    #1;
    check("reset_hold_edge", 16'h0000, 5'd0);
    @(negedge CLK);
    rst_n = 1'b1;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      string nm;
      step(vecs[i].enq, vecs[i].deq, vecs[i].data);
      nm = $sformatf("vec%0d", i);
      $display("vec %0d enq=%0b deq=%0b data=%h -> out=%h count=%0d", i,
               vecs[i].enq, vecs[i].deq, vecs[i].data, out_data, count);
      check(nm, vecs[i].exp_out, vecs[i].exp_cnt);
    end

    // ---------------- async reset mid-run ----------------
    step(1, 0, 16'h0050);
    step(1, 0, 16'h0040);
    step(1, 0, 16'h0070);
    step(1, 0, 16'h0060);
    step(1, 0, 16'h0045);
    check("five_stored", 16'h0040, 5'd5);
    @(negedge CLK);
    enq      = 1'b1;
    inp_data = 16'h0003;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", 16'h0000, 5'd0);
    @(posedge CLK);
    #1;
    check("async_reset_held", 16'h0000, 5'd0);
    @(negedge CLK);
    enq   = 1'b0;
    rst_n = 1'b1;
    step(1, 0, 16'h0077);
    check("after_reset_enq", 16'h0077, 5'd1);
    step(0, 1, 16'h0000);
    check("after_reset_deq", 16'h0000, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
